layer_output_serializer: RTL

- Sits between two neuron layers.
- Captures the parallel outputs of all neurons in one layer in a single cycle, then streams them one value per accepted cycle.
- The stream is in the `myinput`/`myinputValid` form the next layer's neurons consume.
- A downstream ready allows stalling; an optional argmax tracker supports the final classification layer.

---
 rtl/layer_output_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/layer_output_serializer.sv
// Captures one layer's parallel neuron outputs and streams them one element per accepted cycle.
// Optional running argmax over each frame when ARGMAX_EN is defined.
module layer_output_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  localparam int idxWidth  = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic                            in_valid,
  input  logic                            out_ready,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [idxWidth-1:0]             out_idx,
  output logic                            busy,
  output logic                            overrun,
  output logic [idxWidth-1:0]             argmax_idx,
  output logic                            argmax_valid,
  output logic                            dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numNeurons - 1);

  state_t                          state_q;
  logic [numNeurons*dataWidth-1:0] shift_q;
  logic [idxWidth-1:0]             count_q;

  // Handshake: an element moves when out_valid & out_ready are both high at a rising
  // edge; while out_valid is high, out_data/out_idx/out_last do not change until that
  // transfer. in_valid is a single-cycle pulse with no back-pressure.
  logic xfer, last_xfer, accept;

  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;
  assign accept    = in_valid & ((state_q == IDLE) | last_xfer);

  assign out_idx   = count_q;
  assign busy      = out_valid;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        state_q   <= SHIFT;
        out_data  <= in_data[dataWidth-1:0];
        shift_q   <= in_data >> dataWidth;
        count_q   <= '0;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (state_q == SHIFT && xfer) begin
        if (out_last) begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_data <= shift_q[dataWidth-1:0];
          shift_q  <= shift_q >> dataWidth;
          count_q  <= count_q + idxWidth'(1);
          out_last <= ((count_q + idxWidth'(1)) == LAST_IDX);
        end
      end
      // A frame arriving while one is still held is dropped; the held frame is untouched.
      if (in_valid && state_q == SHIFT && !last_xfer) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef ARGMAX_EN
  logic signed [dataWidth-1:0] max_q, max_nxt;
  logic [idxWidth-1:0]         max_idx_q, max_idx_nxt;

  // Strict greater-than keeps the lower index on ties; element 0 seeds the maximum.
  always_comb begin
    max_nxt     = max_q;
    max_idx_nxt = max_idx_q;
    if (count_q == '0 || $signed(out_data) > max_q) begin
      max_nxt     = $signed(out_data);
      max_idx_nxt = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q        <= '0;
      max_idx_q    <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (xfer) begin
        max_q     <= max_nxt;
        max_idx_q <= max_idx_nxt;
        if (out_last) begin
          argmax_idx   <= max_idx_nxt;
          argmax_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule
